// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage branch resolution inputs and the redirect / branch-buffer update outputs.
// master drives EX state and stalls; slave is the redirect controller.
interface branch_redirect_ctrl_if #(
  parameter int PC_BITS  = 12,
  parameter int CNT_BITS = 16
);
  logic                EX_valid;
  logic                EX_brn;
  logic [PC_BITS-1:0]  EX_pc;
  logic                EX_pred_taken;
  logic [PC_BITS-1:0]  EX_pred_target;
  logic                EX_true_taken;
  logic [PC_BITS-1:0]  EX_alu_out;
  logic                MEM_stall;
  logic                F_stall;
  logic                redirect_valid;
  logic [PC_BITS-1:0]  redirect_pc;
  logic                flush_F;
  logic                flush_D;
  logic                bp_upd_valid;
  logic [PC_BITS-1:0]  bp_upd_pc;
  logic [PC_BITS-1:0]  bp_upd_target;
  logic                bp_upd_taken;
  logic                busy;
  logic [CNT_BITS-1:0] branch_cnt;
  logic [CNT_BITS-1:0] mispred_cnt;

  modport master (
    output EX_valid, EX_brn, EX_pc, EX_pred_taken, EX_pred_target,
           EX_true_taken, EX_alu_out, MEM_stall, F_stall,
    input  redirect_valid, redirect_pc, flush_F, flush_D, bp_upd_valid,
           bp_upd_pc, bp_upd_target, bp_upd_taken, busy, branch_cnt, mispred_cnt
  );

  modport slave (
    input  EX_valid, EX_brn, EX_pc, EX_pred_taken, EX_pred_target,
           EX_true_taken, EX_alu_out, MEM_stall, F_stall,
    output redirect_valid, redirect_pc, flush_F, flush_D, bp_upd_valid,
           bp_upd_pc, bp_upd_target, bp_upd_taken, busy, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Resolves EX branches against the fetch prediction, sequences redirect + F/D flush on a
// mispredict, strobes one branch-buffer update per accepted branch, keeps saturating stats.
module branch_redirect_ctrl #(
  parameter int PC_BITS      = 12,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_BITS     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_redirect_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

  localparam int DW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t             state, state_nxt;
  logic [DW-1:0]      drain_cnt;
  logic               acc, mis;
  logic [PC_BITS-1:0] cpc;
  logic               unused_pred_taken;

  // Direction is implied by the predicted target, so only the target is compared.
  assign unused_pred_taken = bus.EX_pred_taken;

  always_comb begin
    acc = bus.EX_valid && bus.EX_brn && !bus.MEM_stall && (state == IDLE);
    cpc = bus.EX_true_taken ? bus.EX_alu_out : bus.EX_pc + PC_BITS'(1);
    mis = acc && (bus.EX_pred_target != cpc);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (mis) state_nxt = REDIRECT;
      REDIRECT: if (!bus.F_stall) state_nxt = (FLUSH_CYCLES > 1) ? DRAIN : IDLE;
      DRAIN:    if (drain_cnt <= DW'(1)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.redirect_valid = (state == REDIRECT);
    bus.flush_F        = (state == REDIRECT) || (state == DRAIN);
    bus.flush_D        = (state == REDIRECT) || (state == DRAIN);
    bus.busy           = (state != IDLE);
  end

  // Reloaded every REDIRECT cycle so it is fresh whenever F_stall finally drops.
  always_ff @(posedge clk) begin
    if (rst)                                 drain_cnt <= '0;
    else if (state == REDIRECT)              drain_cnt <= DW'(FLUSH_CYCLES - 1);
    else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.redirect_pc   <= '0;
      bus.bp_upd_valid  <= 1'b0;
      bus.bp_upd_pc     <= '0;
      bus.bp_upd_target <= '0;
      bus.bp_upd_taken  <= 1'b0;
      bus.branch_cnt    <= '0;
      bus.mispred_cnt   <= '0;
    end else begin
      bus.bp_upd_valid <= acc;
      if (mis) bus.redirect_pc <= cpc;
      if (acc) begin
        bus.bp_upd_pc     <= bus.EX_pc;
        bus.bp_upd_target <= bus.EX_alu_out;
        bus.bp_upd_taken  <= bus.EX_true_taken;
      end
      if (acc && bus.branch_cnt != '1)  bus.branch_cnt  <= bus.branch_cnt + CNT_BITS'(1);
      if (mis && bus.mispred_cnt != '1) bus.mispred_cnt <= bus.mispred_cnt + CNT_BITS'(1);
    end
  end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed recovery scenarios plus random traffic, every cycle checked against a
// behavioural model of the redirect/flush sequence and update stream.
module tb_branch_redirect_ctrl;
  localparam int PC_BITS = 12, FLUSH_CYCLES = 2, CNT_BITS = 16;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0, failed = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl_if #(.PC_BITS(PC_BITS), .CNT_BITS(CNT_BITS)) bus ();

  branch_redirect_ctrl #(.PC_BITS(PC_BITS), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_BITS(CNT_BITS))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // Model: redirect pending flag plus count of flush-only cycles still owed.
  bit          m_redir;
  int          m_flush_left;
  logic [11:0] m_rpc, m_upc, m_utgt;
  bit          m_uv, m_utk;
  int          m_bcnt, m_mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_redir = 0; m_flush_left = 0; m_rpc = '0; m_upc = '0; m_utgt = '0;
    m_uv = 0; m_utk = 0; m_bcnt = 0; m_mcnt = 0;
  endtask

  task automatic cycle();
    bit          busy_m, acc_m, mis_m, fst;
    logic [11:0] cpc_m;
    busy_m = m_redir || (m_flush_left > 0);
    acc_m  = bus.EX_valid && bus.EX_brn && !bus.MEM_stall && !busy_m;
    cpc_m  = bus.EX_true_taken ? bus.EX_alu_out : 12'((int'(bus.EX_pc) + 1) % 4096);
    mis_m  = acc_m && (bus.EX_pred_target != cpc_m);
    fst    = bus.F_stall;
    if (rst) model_reset();
    else begin
      m_uv = acc_m;
      if (acc_m) begin m_upc = bus.EX_pc; m_utgt = bus.EX_alu_out; m_utk = bus.EX_true_taken; end
      if (acc_m && m_bcnt < 65535) m_bcnt++;
      if (mis_m && m_mcnt < 65535) m_mcnt++;
      if (m_redir) begin
        if (!fst) begin m_redir = 0; m_flush_left = FLUSH_CYCLES - 1; end
      end else if (m_flush_left > 0) m_flush_left--;
      else if (mis_m) begin m_redir = 1; m_rpc = cpc_m; end
    end
    @(posedge clk);
    #1;
    chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_redir));
    chk("redirect_pc",    32'(bus.redirect_pc),    32'(m_rpc));
    chk("flush_F",        32'(bus.flush_F),        32'(m_redir || m_flush_left > 0));
    chk("flush_D",        32'(bus.flush_D),        32'(m_redir || m_flush_left > 0));
    chk("busy",           32'(bus.busy),           32'(m_redir || m_flush_left > 0));
    chk("bp_upd_valid",   32'(bus.bp_upd_valid),   32'(m_uv));
    chk("bp_upd_pc",      32'(bus.bp_upd_pc),      32'(m_upc));
    chk("bp_upd_target",  32'(bus.bp_upd_target),  32'(m_utgt));
    chk("bp_upd_taken",   32'(bus.bp_upd_taken),   32'(m_utk));
    chk("branch_cnt",     32'(bus.branch_cnt),     32'(m_bcnt));
    chk("mispred_cnt",    32'(bus.mispred_cnt),    32'(m_mcnt));
  endtask

  task automatic set_br(input logic [11:0] pc, input bit pt, input logic [11:0] ptgt,
                        input bit tt, input logic [11:0] alu);
    bus.EX_valid = 1; bus.EX_brn = 1; bus.EX_pc = pc; bus.EX_pred_taken = pt;
    bus.EX_pred_target = ptgt; bus.EX_true_taken = tt; bus.EX_alu_out = alu;
  endtask

  task automatic idle_in();
    bus.EX_valid = 0; bus.EX_brn = 0;
  endtask

  initial begin
    int          cnt;
    logic [11:0] pc, alu, cpc;
    bit          tt;
    model_reset();
    rst = 1; bus.MEM_stall = 0; bus.F_stall = 0;
    set_br(12'h0, 0, 12'h0, 0, 12'h0); idle_in();
    repeat (2) cycle();
    chk("reset_redirect_valid", 32'(bus.redirect_valid), 0);
    chk("reset_branch_cnt", 32'(bus.branch_cnt), 0);
    rst = 0;
    cycle();

    // Correct prediction: update only
    set_br(12'h010, 1, 12'h040, 1, 12'h040); cycle(); idle_in();
    chk("t2_upd_valid", 32'(bus.bp_upd_valid), 1);
    chk("t2_upd_pc", 32'(bus.bp_upd_pc), 32'h010);
    chk("t2_upd_tgt", 32'(bus.bp_upd_target), 32'h040);
    chk("t2_upd_taken", 32'(bus.bp_upd_taken), 1);
    chk("t2_no_redirect", 32'(bus.redirect_valid), 0);
    chk("t2_branch_cnt", 32'(bus.branch_cnt), 1);
    chk("t2_mispred_cnt", 32'(bus.mispred_cnt), 0);
    cycle();
    chk("t2_upd_one_pulse", 32'(bus.bp_upd_valid), 0);

    // Direction miss
    set_br(12'h020, 0, 12'h021, 1, 12'h080); cycle(); idle_in();
    chk("t3_redirect_valid", 32'(bus.redirect_valid), 1);
    chk("t3_redirect_pc", 32'(bus.redirect_pc), 32'h080);
    chk("t3_flush_F", 32'(bus.flush_F), 1);
    chk("t3_mispred_cnt", 32'(bus.mispred_cnt), 1);
    cycle();
    chk("t3_drain_rv", 32'(bus.redirect_valid), 0);
    chk("t3_drain_flush_D", 32'(bus.flush_D), 1);
    cycle();
    chk("t3_flush_done", 32'(bus.flush_F), 0);
    chk("t3_idle", 32'(bus.busy), 0);

    // Not-taken miss at PC wrap, then fetch stalls the redirect
    set_br(12'hFFF, 1, 12'h100, 0, 12'h123); cycle();
    chk("t4_redirect_pc_wrap", 32'(bus.redirect_pc), 32'h000);
    cnt = bus.redirect_valid ? 1 : 0;
    set_br(12'h300, 0, 12'h301, 1, 12'h555);
    bus.F_stall = 1;
    repeat (3) begin
      cycle();
      if (bus.redirect_valid) cnt++;
      chk("t5_held_pc", 32'(bus.redirect_pc), 32'h000);
      chk("t5_busy_no_upd", 32'(bus.bp_upd_valid), 0);
    end
    bus.F_stall = 0;
    cycle(); idle_in();
    if (bus.redirect_valid) cnt++;
    chk("t5_rv_cycles", 32'(cnt), 4);
    chk("t5_drain_flush", 32'(bus.flush_F), 1);
    cycle();
    chk("t5_idle", 32'(bus.busy), 0);
    chk("t5_no_count", 32'(bus.branch_cnt), 3);

    // MEM_stall blocks acceptance
    set_br(12'h050, 0, 12'h051, 0, 12'h200);
    bus.MEM_stall = 1;
    cnt = 0;
    repeat (3) begin cycle(); if (bus.bp_upd_valid) cnt++; end
    bus.MEM_stall = 0;
    cycle(); idle_in(); if (bus.bp_upd_valid) cnt++;
    cycle(); if (bus.bp_upd_valid) cnt++;
    chk("t6_one_update", 32'(cnt), 1);
    chk("t6_branch_cnt", 32'(bus.branch_cnt), 4);

    // Reset mid-REDIRECT
    set_br(12'h070, 1, 12'h090, 1, 12'h0A0); cycle(); idle_in();
    bus.F_stall = 1;
    chk("t1_in_redirect", 32'(bus.redirect_valid), 1);
    rst = 1;
    repeat (3) begin
      cycle();
      chk("t1_rst_rv", 32'(bus.redirect_valid), 0);
      chk("t1_rst_pc", 32'(bus.redirect_pc), 0);
      chk("t1_rst_busy", 32'(bus.busy), 0);
      chk("t1_rst_cnt", 32'(bus.branch_cnt), 0);
    end
    rst = 0; bus.F_stall = 0;
    cycle();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      pc  = 12'($urandom);
      alu = 12'($urandom);
      tt  = 1'($urandom);
      cpc = tt ? alu : 12'((int'(pc) + 1) % 4096);
      set_br(pc, 1'($urandom), ($urandom_range(0, 2) == 0) ? 12'($urandom) : cpc, tt, alu);
      bus.EX_valid  = ($urandom_range(0, 3) != 0);
      bus.EX_brn    = ($urandom_range(0, 3) != 0);
      bus.MEM_stall = ($urandom_range(0, 4) == 0);
      bus.F_stall   = ($urandom_range(0, 2) == 0);
      cycle();
    end
    idle_in(); bus.MEM_stall = 0; bus.F_stall = 0;
    repeat (4) cycle();

    // Counter saturation
    rst = 1; cycle(); rst = 0;
    for (int i = 0; i < 65536 + 5; i++) begin
      pc = 12'($urandom);
      set_br(pc, 0, 12'((int'(pc) + 1) % 4096), 0, 12'($urandom));
      cycle();
    end
    idle_in(); cycle();
    chk("sat_branch_cnt", 32'(bus.branch_cnt), 32'hFFFF);
    chk("sat_mispred_cnt", 32'(bus.mispred_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
